instr_loader: RTL and testbench

- Program-load stage directly upstream of the non-pipelined MIPS core. Drives the core's instruction-memory write port (instrWrite_in, instr_address_in, instr_in) and holds the core in reset while loading.
- Input is a byte stream with a valid/ready handshake:
  - 16-bit big-endian word-count header first.
  - Then that many 32-bit instruction words, MSB byte first.
- Releases the core's reset only after the last word is written.

---
 rtl/instr_loader.sv | 157 +++++++++++++++
 tb/tb_instr_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream program loader driving the core's instruction-memory write port
// Holds the core in reset while a header-prefixed stream of big-endian words is written.
module instr_loader #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MEM_WORDS = 256
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              start_in,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid_in,
  output logic              byte_ready_out,
  output logic              instrWrite_out,
  output logic [ADDR_W-1:0] instr_address_out,
  output logic [31:0]       instr_out,
  output logic              cpu_reset_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              error_out,
  output logic [15:0]       words_loaded_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_HDR_LO = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_WORD   = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       words_q, words_d;
  logic              ready_q, ready_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              accept;

  assign accept = byte_valid_in && ready_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    words_d = words_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_in) begin
          state_d = S_HDR_HI;
          words_d = '0;
          addr_d  = BASE_ADDR;
        end
      end
      S_HDR_HI: begin
        if (accept) begin
          count_d[15:8] = byte_in;
          state_d       = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          count_d[7:0] = byte_in;
          state_d      = S_CHECK;
        end
      end
      S_CHECK: begin
        idx_d = '0;
        if (count_q == 16'd0) begin
          state_d = S_DONE;
        end else if ({16'd0, count_q} > MEM_WORDS) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_WORD;
        end
      end
      S_WORD: begin
        if (accept) begin
          idx_d = idx_q + 2'd1;
          asm_d = {asm_q[15:0], byte_in};
          if (idx_q == 2'd3) begin
            instr_d = {asm_q, byte_in};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(4);
        words_d = words_q + 16'd1;
        state_d = (words_q + 16'd1 == count_q) ? S_DONE : S_WORD;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of what the next state implies.
    ready_d   = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) || (state_d == S_WORD);
    wr_d      = (state_d == S_WRITE);
    busy_d    = (state_d >= S_HDR_HI) && (state_d <= S_WRITE);
    done_d    = (state_d == S_DONE);
    error_d   = (state_d == S_ERROR);
    cpu_rst_d = (state_d != S_DONE);
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      asm_q     <= '0;
      instr_q   <= '0;
      addr_q    <= BASE_ADDR;
      words_q   <= '0;
      ready_q   <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      instr_q   <= instr_d;
      addr_q    <= addr_d;
      words_q   <= words_d;
      ready_q   <= ready_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign byte_ready_out    = ready_q;
  assign instrWrite_out    = wr_q;
  assign instr_address_out = addr_q;
  assign instr_out         = instr_q;
  assign cpu_reset_out     = cpu_rst_q;
  assign busy_out          = busy_q;
  assign done_out          = done_q;
  assign error_out         = error_q;
  assign words_loaded_out  = words_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - self-checking bench for instr_loader
// Expected writes are derived from the program list: word i lands at BASE + 4*i.
module tb_instr_loader;

  logic        clock_in = 1'b0;
  logic        reset_in;
  logic        start_in;
  logic [7:0]  byte_in;
  logic        byte_valid_in;
  logic        byte_ready_out;
  logic        instrWrite_out;
  logic [31:0] instr_address_out;
  logic [31:0] instr_out;
  logic        cpu_reset_out;
  logic        busy_out;
  logic        done_out;
  logic        error_out;
  logic [15:0] words_loaded_out;

  instr_loader dut (
    .clock_in          (clock_in),
    .reset_in          (reset_in),
    .start_in          (start_in),
    .byte_in           (byte_in),
    .byte_valid_in     (byte_valid_in),
    .byte_ready_out    (byte_ready_out),
    .instrWrite_out    (instrWrite_out),
    .instr_address_out (instr_address_out),
    .instr_out         (instr_out),
    .cpu_reset_out     (cpu_reset_out),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .error_out         (error_out),
    .words_loaded_out  (words_loaded_out)
  );

  always #5 clock_in = ~clock_in;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc          = 0;
  int          wr_released  = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [31:0] prog_q[$];
  logic [31:0] mem [0:255];

  always @(posedge clock_in) cyc <= cyc + 1;

  // Stand-in for the core's instruction memory, sampled away from the active edge.
  always @(negedge clock_in) begin
    if (!reset_in && instrWrite_out) begin
      wr_addr_q.push_back(instr_address_out);
      wr_data_q.push_back(instr_out);
      wr_cyc_q.push_back(cyc);
      mem[instr_address_out[9:2]] <= instr_out;
      if (!cpu_reset_out) wr_released <= wr_released + 1;
    end
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    wr_released = 0;
  endtask

  task automatic do_start();
    @(negedge clock_in);
    byte_valid_in = 1'b0;
    start_in      = 1'b1;
    @(negedge clock_in);
    start_in      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clock_in);
      byte_valid_in = 1'b0;
      byte_in       = 8'($urandom);
    end
    @(negedge clock_in);
    byte_valid_in = 1'b1;
    byte_in       = b;
    n = 0;
    while (!byte_ready_out && n < 64) begin
      @(negedge clock_in);
      n++;
    end
    tests_run++;
    if (byte_ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL send_byte_ready: ready=%b required 1 within 64 cycles", byte_ready_out);
    end
  endtask

  task automatic send_program(input logic [15:0] hdr, input int maxgap, input bit mid_start);
    send_byte(hdr[15:8], $urandom_range(0, maxgap));
    send_byte(hdr[7:0], $urandom_range(0, maxgap));
    if (mid_start) do_start();
    foreach (prog_q[i]) begin
      for (int k = 3; k >= 0; k--) send_byte(prog_q[i][8*k +: 8], $urandom_range(0, maxgap));
    end
    @(negedge clock_in);
    byte_valid_in = 1'b0;
  endtask

  task automatic wait_end(output int ncyc);
    ncyc = 0;
    while (!(done_out || error_out) && ncyc < 3000) begin
      @(negedge clock_in);
      ncyc++;
    end
    tests_run++;
    if (!(done_out || error_out)) begin
      tests_failed++;
      $display("FAIL wait_end: no done/error after %0d cycles", ncyc);
    end
  endtask

  task automatic check_load(input string name, input logic [15:0] exp_words);
    tests_run++;
    if (wr_addr_q.size() != prog_q.size()) begin
      tests_failed++;
      $display("FAIL %s_strobes: got %0d required %0d", name, wr_addr_q.size(), prog_q.size());
    end
    for (int i = 0; i < prog_q.size() && i < wr_addr_q.size(); i++) begin
      tests_run++;
      if (wr_addr_q[i] !== 32'(4 * i) || wr_data_q[i] !== prog_q[i]) begin
        tests_failed++;
        $display("FAIL %s_write[%0d]: got %h@%h required %h@%h", name, i,
                 wr_data_q[i], wr_addr_q[i], prog_q[i], 32'(4 * i));
      end
    end
    tests_run++;
    if (done_out !== 1'b1 || error_out !== 1'b0 || cpu_reset_out !== 1'b0 || busy_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_status: done=%b err=%b cpu_rst=%b busy=%b required 1 0 0 0", name,
               done_out, error_out, cpu_reset_out, busy_out);
    end
    tests_run++;
    if (words_loaded_out !== exp_words) begin
      tests_failed++;
      $display("FAIL %s_words: got %0d required %0d", name, words_loaded_out, exp_words);
    end
    tests_run++;
    if (wr_released != 0) begin
      tests_failed++;
      $display("FAIL %s_cpu_reset_held: %0d writes with core released, required 0", name, wr_released);
    end
  endtask

  task automatic random_prog(input int n);
    prog_q.delete();
    repeat (n) prog_q.push_back($urandom);
  endtask

  task automatic test_reset();
    reset_in = 1'b1; start_in = 1'b0; byte_valid_in = 1'b0; byte_in = 8'h00;
    repeat (3) @(negedge clock_in);
    tests_run++;
    if (byte_ready_out !== 1'b0 || instrWrite_out !== 1'b0 || busy_out !== 1'b0 ||
        done_out !== 1'b0 || error_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: rdy=%b wr=%b busy=%b done=%b err=%b required all 0",
               byte_ready_out, instrWrite_out, busy_out, done_out, error_out);
    end
    tests_run++;
    if (instr_address_out !== 32'h0 || instr_out !== 32'h0 || words_loaded_out !== 16'h0 ||
        cpu_reset_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_values: addr=%h instr=%h words=%0d cpu_rst=%b required 0 0 0 1",
               instr_address_out, instr_out, words_loaded_out, cpu_reset_out);
    end
    reset_in = 1'b0;
    // Header bytes offered before start must not be taken.
    byte_valid_in = 1'b1; byte_in = 8'h00;
    repeat (3) @(negedge clock_in);
    tests_run++;
    if (byte_ready_out !== 1'b0 || busy_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_no_accept: rdy=%b busy=%b required 0 0", byte_ready_out, busy_out);
    end
    byte_valid_in = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    prog_q.delete();
    prog_q.push_back(32'h20080005);
    prog_q.push_back(32'h20090007);
    clear_log();
    do_start();
    tests_run++;
    if (busy_out !== 1'b1 || byte_ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_started: busy=%b rdy=%b required 1 1", busy_out, byte_ready_out);
    end
    send_program(16'd2, 0, 1'b0);
    wait_end(n);
    check_load("basic", 16'd2);
    tests_run++;
    if (wr_cyc_q.size() == 2 && wr_cyc_q[1] - wr_cyc_q[0] != 5) begin
      tests_failed++;
      $display("FAIL basic_throughput: got %0d cycles/word required 5", wr_cyc_q[1] - wr_cyc_q[0]);
    end
  endtask

  task automatic test_zero();
    int n;
    prog_q.delete();
    clear_log();
    do_start();
    send_program(16'd0, 0, 1'b0);
    wait_end(n);
    tests_run++;
    if (n > 2) begin
      tests_failed++;
      $display("FAIL zero_latency: done after %0d extra cycles required <=2", n);
    end
    check_load("zero", 16'd0);
  endtask

  task automatic test_error();
    int n;
    prog_q.delete();
    clear_log();
    do_start();
    send_program(16'h0101, 0, 1'b0);
    wait_end(n);
    tests_run++;
    if (error_out !== 1'b1 || done_out !== 1'b0 || cpu_reset_out !== 1'b1 || busy_out !== 1'b0 ||
        wr_addr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL error_status: err=%b done=%b cpu_rst=%b busy=%b writes=%0d required 1 0 1 0 0",
               error_out, done_out, cpu_reset_out, busy_out, wr_addr_q.size());
    end
    random_prog(1);
    clear_log();
    do_start();
    send_program(16'd1, 0, 1'b0);
    wait_end(n);
    check_load("after_error", 16'd1);
  endtask

  task automatic test_gaps();
    int n;
    random_prog(4);
    clear_log();
    do_start();
    send_program(16'd4, 3, 1'b1);
    wait_end(n);
    check_load("gaps", 16'd4);
  endtask

  task automatic test_max();
    int n;
    random_prog(256);
    clear_log();
    do_start();
    send_program(16'd256, 0, 1'b0);
    wait_end(n);
    check_load("max", 16'd256);
    tests_run++;
    if (wr_addr_q.size() == 256 && wr_addr_q[255] !== 32'h3FC) begin
      tests_failed++;
      $display("FAIL max_last_addr: got %h required 000003fc", wr_addr_q[255]);
    end
  endtask

  task automatic test_midreset();
    int n;
    random_prog(3);
    clear_log();
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int k = 3; k >= 0; k--) send_byte(prog_q[0][8*k +: 8], 0);
    send_byte(prog_q[1][31:24], 0);
    send_byte(prog_q[1][23:16], 0);
    @(negedge clock_in);
    byte_valid_in = 1'b1;
    byte_in       = prog_q[1][15:8];
    reset_in      = 1'b1;
    @(negedge clock_in);
    reset_in      = 1'b0;
    byte_valid_in = 1'b0;
    tests_run++;
    if (busy_out !== 1'b0 || byte_ready_out !== 1'b0 || cpu_reset_out !== 1'b1 ||
        instr_address_out !== 32'h0 || words_loaded_out !== 16'h0 || done_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_state: busy=%b rdy=%b cpu_rst=%b addr=%h words=%0d done=%b required 0 0 1 0 0 0",
               busy_out, byte_ready_out, cpu_reset_out, instr_address_out, words_loaded_out, done_out);
    end
    tests_run++;
    if (wr_addr_q.size() != 1) begin
      tests_failed++;
      $display("FAIL midreset_writes: got %0d required 1", wr_addr_q.size());
    end
    random_prog(3);
    clear_log();
    do_start();
    send_program(16'd3, 1, 1'b0);
    wait_end(n);
    check_load("after_reset", 16'd3);
  endtask

  task automatic test_back_to_back();
    int n;
    prog_q.delete();
    prog_q.push_back(32'h20080005);
    prog_q.push_back(32'h20090007);
    prog_q.push_back(32'h01095020);
    clear_log();
    do_start();
    send_program(16'd3, 0, 1'b0);
    wait_end(n);
    check_load("core_prog", 16'd3);
    @(negedge clock_in);
    tests_run++;
    if (mem[2] !== 32'h01095020) begin
      tests_failed++;
      $display("FAIL core_mem_0x8: got %h required 01095020", mem[2]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_error();
    test_gaps();
    test_max();
    test_midreset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
